// File: rtl/ids_dma_pkg.sv
// Shared types and constants for the ids_dma word-copy DMA initiator.
package ids_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RDATA,
    WR,
    DONE
  } state_t;

  localparam logic [3:0] SIZE_WORD = 4'hF;

  // Upper address nibble of the PIM buffer SRAM and the Hybrid-PIM regions
  localparam logic [3:0] ADDR_BUF = 4'h2;
  localparam logic [3:0] ADDR_PIM = 4'h4;

endpackage

// File: rtl/ids_dma.sv
// Word-granular DMA initiator: copies i_len words from src to dst over a
// req/gnt shared bus, tolerating grant loss in any cycle.
module ids_dma
  import ids_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [31:0]      i_src_addr,
  input  logic [31:0]      i_dst_addr,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic             o_req_dma,
  input  logic             i_gnt_dma,
  output logic [31:0]      o_dma_addr,
  output logic             o_dma_write,
  output logic             o_dma_read,
  output logic [3:0]       o_dma_size,
  output logic [31:0]      o_dma_din,
  input  logic [31:0]      i_dma_dout
);

  state_t             state_q, state_d;
  logic [31:0]        src_ptr, dst_ptr, data_q;
  logic [LEN_W-1:0]   remaining;
  logic               err_q;
  logic               misaligned, len_zero;

  assign misaligned = (|i_src_addr[1:0]) | (|i_dst_addr[1:0]);
  assign len_zero   = (i_len == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus outputs are decoded from state alone so a reset clears them at once
  always_comb begin
    state_d     = state_q;
    o_req_dma   = 1'b0;
    o_dma_read  = 1'b0;
    o_dma_write = 1'b0;
    o_dma_addr  = 32'd0;
    o_dma_din   = 32'd0;
    o_dma_size  = 4'h0;
    o_done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = (misaligned || len_zero) ? DONE : RD;
        end
      end
      RD: begin
        o_req_dma  = 1'b1;
        o_dma_read = 1'b1;
        o_dma_addr = src_ptr;
        o_dma_size = SIZE_WORD;
        if (i_gnt_dma) state_d = RDATA;
      end
      RDATA: begin
        // Keep requesting so the core cannot slip in between read and write
        o_req_dma = 1'b1;
        state_d   = WR;
      end
      WR: begin
        o_req_dma   = 1'b1;
        o_dma_write = 1'b1;
        o_dma_addr  = dst_ptr;
        o_dma_din   = data_q;
        o_dma_size  = SIZE_WORD;
        if (i_gnt_dma) state_d = (remaining == LEN_W'(1)) ? DONE : RD;
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy = (state_q != IDLE);
  assign o_err  = err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      src_ptr   <= 32'd0;
      dst_ptr   <= 32'd0;
      remaining <= '0;
      data_q    <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            src_ptr   <= i_src_addr;
            dst_ptr   <= i_dst_addr;
            remaining <= i_len;
            err_q     <= misaligned;
          end
        end
        RD: begin
          if (i_gnt_dma) src_ptr <= src_ptr + 32'd4;
        end
        RDATA: begin
          // Read data arrives one cycle after the granted read, grant or not
          data_q <= i_dma_dout;
        end
        WR: begin
          if (i_gnt_dma) begin
            dst_ptr   <= dst_ptr + 32'd4;
            remaining <= remaining - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ids_dma.sv
// Randomised scoreboard bench for ids_dma with a behavioural bus memory.
module tb_ids_dma;
  import ids_dma_pkg::*;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      src = '0, dst = '0;
  logic [LEN_W-1:0] len = '0;
  logic             gnt = 1'b0;
  logic [31:0]      dout = '0;
  logic             o_busy, o_done, o_err, o_req_dma, o_dma_write, o_dma_read;
  logic [31:0]      o_dma_addr, o_dma_din;
  logic [3:0]       o_dma_size;

  always #5 clk = ~clk;

  ids_dma #(.LEN_W(LEN_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_src_addr(src), .i_dst_addr(dst), .i_len(len),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_req_dma(o_req_dma), .i_gnt_dma(gnt),
    .o_dma_addr(o_dma_addr), .o_dma_write(o_dma_write), .o_dma_read(o_dma_read),
    .o_dma_size(o_dma_size), .o_dma_din(o_dma_din), .i_dma_dout(dout)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          tests = 0, fails = 0;
  wr_t         exp_wr[$];
  logic        exp_done[$];
  wr_t         e_mon;
  logic [31:0] mem [logic [31:0]];
  int          cyc = 0, start_cyc = 0, exp_lat = -1;
  int          gnt_mode = 0, stall_rd = 0, stall_wr = 0;
  bit          hold_wr = 0, rd_flag = 0, no_bus = 0;
  logic [31:0] rd_addr = '0;
  int          done_cnt = 0, wr_cnt = 0, done_base = 0;

  localparam logic [31:0] BUF = {ADDR_BUF, 28'h0};
  localparam logic [31:0] PIM = {ADDR_PIM, 28'h0};

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] all_outs();
    return {22'd0, o_busy, o_done, o_err, o_req_dma, o_dma_write, o_dma_read,
            o_dma_size, o_dma_addr, o_dma_din};
  endfunction

  // Bus slave: grant policy plus read data one cycle after a granted read
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (rd_flag) begin
      dout    = mem.exists(rd_addr) ? mem[rd_addr] : 32'hDEAD_BEEF;
      rd_flag = 0;
    end else begin
      dout = $urandom;
    end
    case (gnt_mode)
      1: gnt = ($urandom_range(0, 9) < 7);
      2: begin
        if (o_dma_read && stall_rd > 0) begin
          gnt = 1'b0; stall_rd--;
        end else if (o_dma_write && stall_wr > 0) begin
          gnt = 1'b0; stall_wr--;
        end else gnt = 1'b1;
      end
      3: gnt = !(o_req_dma && !o_dma_read && !o_dma_write);
      default: gnt = 1'b1;
    endcase
    if (hold_wr && o_dma_write) gnt = 1'b0;
  end

  // Monitor: accepted bus accesses and done pulses are checked here
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (o_dma_read && o_dma_write) begin
        tests++; fails++;
        $display("FAIL rd_wr_both: got 1 expected 0");
      end
      if (((o_dma_read || o_dma_write) ? SIZE_WORD : 4'h0) !== o_dma_size) begin
        tests++; fails++;
        $display("FAIL size: got %0h with rd=%0b wr=%0b", o_dma_size, o_dma_read, o_dma_write);
      end
      if (no_bus && o_req_dma) begin
        tests++; fails++;
        $display("FAIL no_bus_req: got req=1 expected 0");
      end
      if (o_req_dma && gnt && o_dma_read) begin
        rd_flag = 1;
        rd_addr = o_dma_addr;
      end
      if (o_req_dma && gnt && o_dma_write) begin
        mem[o_dma_addr] = o_dma_din;
        wr_cnt++;
        if (exp_wr.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", o_dma_addr, o_dma_din);
        end else begin
          e_mon = exp_wr.pop_front();
          check("wr_addr", 96'(o_dma_addr), 96'(e_mon.addr));
          check("wr_data", 96'(o_dma_din), 96'(e_mon.data));
        end
      end
      if (o_done) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done=1 expected none");
        end else begin
          check("done_err", 96'(o_err), 96'(exp_done.pop_front()));
          if (exp_lat >= 0) check("latency", 96'(cyc - start_cyc), 96'(exp_lat));
        end
      end
    end
  end

  task automatic do_start(input logic [31:0] s, input logic [31:0] d,
                          input logic [LEN_W-1:0] n, input int lat);
    bit bad;
    @(posedge clk); #2;
    bad       = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
    done_base = done_cnt;
    if (bad || n == 0) begin
      no_bus = 1;
      exp_done.push_back(bad);
    end else begin
      no_bus = 0;
      for (int i = 0; i < int'(n); i++)
        exp_wr.push_back('{addr: d + 32'(4 * i), data: mem[s + 32'(4 * i)]});
      exp_done.push_back(1'b0);
    end
    src = s; dst = d; len = n; start = 1'b1;
    start_cyc = cyc; exp_lat = lat;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt <= done_base && k < budget) begin
      @(posedge clk); k++;
    end
    tests++;
    if (done_cnt <= done_base) begin
      fails++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
    end
    @(posedge clk); #2;
    check("wr_queue_drained", 96'(exp_wr.size()), 96'd0);
    no_bus = 0;
  endtask

  task automatic preload(input logic [31:0] s, input int n);
    for (int i = 0; i < n; i++) mem[s + 32'(4 * i)] = $urandom;
  endtask

  initial begin
    int k, base;
    logic [31:0] s, d;
    logic [LEN_W-1:0] n;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 check("reset_outputs", all_outs(), 96'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    check("idle_busy", 96'(o_busy), 96'd0);

    // Continuous grant, three words
    mem[BUF] = 32'h11111111; mem[BUF + 4] = 32'h22222222; mem[BUF + 8] = 32'h33333333;
    gnt_mode = 0;
    do_start(BUF, PIM, 3, 10);
    wait_done(100);
    check("pim0", 96'(mem[PIM]), 96'h11111111);
    check("pim1", 96'(mem[PIM + 4]), 96'h22222222);
    check("pim2", 96'(mem[PIM + 8]), 96'h33333333);

    // Same copy with 2 RD and 3 WR stall cycles
    mem[PIM] = 0; mem[PIM + 4] = 0; mem[PIM + 8] = 0;
    gnt_mode = 2; stall_rd = 2; stall_wr = 3;
    do_start(BUF, PIM, 3, 15);
    wait_done(100);
    check("stall_wr_count", 96'(wr_cnt), 96'd6);
    check("stall_pim2", 96'(mem[PIM + 8]), 96'h33333333);

    // Grant dropped in every RDATA cycle
    mem[BUF + 32'h100] = 32'hA5A50001; mem[BUF + 32'h104] = 32'h5A5A0002;
    gnt_mode = 3;
    do_start(BUF + 32'h100, PIM + 32'h100, 2, 7);
    wait_done(100);
    check("rdata_word1", 96'(mem[PIM + 32'h104]), 96'h5A5A0002);

    // Zero length and misaligned addresses
    gnt_mode = 0;
    do_start(BUF, PIM, 0, 1);
    wait_done(20);
    do_start(BUF + 2, PIM, 2, 1);
    wait_done(20);
    repeat (3) @(posedge clk);
    #2 check("err_hold", 96'(o_err), 96'd1);
    do_start(BUF + 32'h200, PIM + 32'h40, 1, 4);
    mem[BUF + 32'h200] = 32'hCAFE0001;
    exp_wr[0].data = 32'hCAFE0001;
    wait_done(20);
    check("err_cleared", 96'(o_err), 96'd0);
    do_start(BUF, PIM + 1, 1, 1);
    wait_done(20);

    // Reset while word 2 of 4 is waiting in WR
    preload(BUF + 32'h300, 4);
    base = wr_cnt;
    do_start(BUF + 32'h300, PIM + 32'h300, 4, -1);
    k = 0;
    while (wr_cnt < base + 1 && k < 100) begin @(negedge clk); k++; end
    hold_wr = 1;
    @(negedge clk);
    k = 0;
    while (!o_dma_write && k < 100) begin @(negedge clk); k++; end
    check("reach_wr2", 96'(o_dma_write), 96'd1);
    #1 rst_n = 1'b0;
    #1 check("abort_outputs", all_outs(), 96'd0);
    exp_wr.delete(); exp_done.delete();
    hold_wr = 0; rd_flag = 0;
    base = done_cnt;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    check("abort_no_done", 96'(done_cnt), 96'(base));
    check("abort_one_write", 96'(mem[PIM + 32'h304] === mem[BUF + 32'h304]), 96'd0);
    do_start(BUF + 32'h300, PIM + 32'h300, 1, 4);
    wait_done(20);

    // Start pulses while busy are ignored
    preload(BUF + 32'h400, 3);
    gnt_mode = 1;
    do_start(BUF + 32'h400, PIM + 32'h400, 3, -1);
    repeat (2) @(posedge clk);
    #2 check("busy_mid", 96'(o_busy), 96'd1);
    src = BUF + 1; dst = PIM + 32'h800; len = 5; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_done(200);

    // Randomised copies
    for (int t = 0; t < 10; t++) begin
      n = LEN_W'($urandom_range(1, 6));
      s = BUF | {20'd0, 8'($urandom_range(0, 255)), 4'd0};
      d = PIM | {20'd0, 8'($urandom_range(0, 255)), 4'd0};
      if ($urandom_range(0, 5) == 0) s[1:0] = 2'($urandom_range(1, 3));
      preload(s, int'(n));
      do_start(s, d, n, -1);
      wait_done(300);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ids_dma.md
Name: ids_dma

Overview:
- Word-granular DMA initiator that drives the DMA master port of the DMEM-side bus.
- Copies i_len 32-bit words from a source address to a destination address, typically between the PIM buffer SRAM (0x2xxx_xxxx) and the Hybrid-PIM (0x4xxx_xxxx).
- Requests the bus with req/gnt and tolerates losing grant to the higher-priority core at any cycle.
- Configured by start/addr/len inputs from a control register block; reports busy/done/err.

Parameters:
- LEN_W, 16, width of the word-count input; maximum transfer is 2^LEN_W-1 words.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle start pulse; sampled only in IDLE
- i_src_addr  in  32  source byte address; must be word aligned
- i_dst_addr  in  32  destination byte address; must be word aligned
- i_len  in  LEN_W  number of words to copy
- o_busy  out  1  high from the cycle after an accepted start until DONE exits
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  valid with o_done; set when src or dst is misaligned
- o_req_dma  out  1  bus request
- i_gnt_dma  in  1  bus grant
- o_dma_addr  out  32  bus address
- o_dma_write  out  1  write strobe
- o_dma_read  out  1  read strobe
- o_dma_size  out  4  byte enables; always 4'hF during access, 0 otherwise
- o_dma_din  out  32  write data
- i_dma_dout  in  32  read data; valid exactly one cycle after a granted read cycle

Behaviour:
- Reset: the FSM goes to IDLE and all outputs are 0, including o_busy, o_done, o_err, o_req_dma, strobes, size, addr and din. Internal pointers, count and data register are cleared.
- Bus transfer rule: an access is accepted in a cycle where o_req_dma and i_gnt_dma are both high. Only then does the bus route addr/strobes. An un-granted cycle has no effect and is retried with identical signals.
- FSM states are IDLE, RD, RDATA, WR, DONE.
- IDLE -> RD on i_start when i_len != 0 and i_src_addr[1:0] == 0 and i_dst_addr[1:0] == 0. This latches src_ptr, dst_ptr and remaining = i_len.
- IDLE -> DONE on i_start with i_len == 0; o_err = 0, and no bus activity occurs.
- IDLE -> DONE on i_start with a misaligned src or dst; o_err = 1, and no bus activity occurs.
- RD: drive o_req_dma = 1, o_dma_read = 1, o_dma_addr = src_ptr, size = 4'hF.
  - If gnt: go to RDATA and set src_ptr += 4.
  - Otherwise: stay in RD.
- RDATA: o_req_dma stays 1 to hold arbitration and strobes are 0. Capture i_dma_dout into data_q unconditionally; the data is valid regardless of current gnt. Go to WR.
- WR: drive o_req_dma = 1, o_dma_write = 1, o_dma_addr = dst_ptr, o_dma_din = data_q, size = 4'hF.
  - If gnt: set dst_ptr += 4 and remaining -= 1. Go to DONE if remaining was 1, else go to RD.
  - Otherwise: stay in WR.
- DONE: o_done = 1 for one cycle with o_err valid; o_req_dma = 0. Go to IDLE.
- o_err holds its value until the next accepted start.
- o_busy = 1 in RD, RDATA, WR and DONE.
- Throughput: 3 cycles per word with continuous grant. A full copy of N words takes 3N cycles from the first RD to the DONE entry.
- i_start while not IDLE is ignored.
- Pointers are 32-bit and wrap modulo 2^32. There is no boundary check.
- o_dma_read and o_dma_write are never both 1 in the same cycle.
- Async reset mid-transfer aborts immediately: all outputs go to 0 and no done pulse is produced.

Decomposition:
- Package ids_dma_pkg holds:
  - the state enum (IDLE, RD, RDATA, WR, DONE);
  - SIZE_WORD = 4'hF;
  - region tags ADDR_BUF = 4'h2 and ADDR_PIM = 4'h4, for benches and firmware headers.
- Single module; no sub-module is warranted.

Test Plan:
- Continuous gnt, src 0x2000_0000, dst 0x4000_0000, len 3, buffer preloaded with 0x11111111/0x22222222/0x33333333 -> PIM writes the 3 words in order to 0x4000_0000/04/08. o_done pulses 9 cycles after the first RD cycle, and o_err = 0.
- Same transfer with gnt dropped for 2 cycles in RD and 3 cycles in WR -> identical data and addresses. Strobes are held during the stall, there are no duplicate writes, and o_done is delayed by exactly 5 cycles.
- Gnt low during the RDATA cycle -> data_q is still captured correctly and the written value matches the source.
- i_len = 0 -> o_done one cycle after start, o_err = 0, and o_req_dma never asserts.
- src 0x2000_0002 -> o_done with o_err = 1 and no bus access. A following aligned start succeeds and clears o_err.
- i_rst_n asserted in the WR state of word 2 of 4 -> all outputs 0 immediately and no o_done. A restart with len 1 completes normally.
- i_start pulsed while busy -> ignored; the original transfer completes unchanged.
